// File: rtl/trace_buffer_pkg.sv
// trace_buffer_pkg
//   Shared definitions for the trace recorder: FSM state encoding, capture
//   mode encoding, default geometry and a helper that folds the reserved
//   mode value onto TRIG.
package trace_buffer_pkg;

  typedef enum logic [1:0] {
    TB_IDLE  = 2'd0,
    TB_ARMED = 2'd1,
    TB_POST  = 2'd2,
    TB_DONE  = 2'd3
  } tb_state_e;

  typedef enum logic [1:0] {
    TB_WRAP = 2'd0,
    TB_TRIG = 2'd1,
    TB_FILL = 2'd2
  } tb_mode_e;

  localparam int TB_DEFAULT_SW    = 32;
  localparam int TB_DEFAULT_DEPTH = 64;
  localparam int TB_DEFAULT_CW    = 16;

  // Mode 3 has no meaning of its own and behaves exactly like TRIG.
  function automatic tb_mode_e norm_mode(input logic [1:0] m);
    tb_mode_e r;
    case (m)
      2'd0:    r = TB_WRAP;
      2'd2:    r = TB_FILL;
      default: r = TB_TRIG;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/trace_buffer_ram.sv
// trace_buffer_ram
//   Simple dual-port RAM, DEPTH x DW, one write port and one synchronous
//   read port, no reset (maps onto block RAM).
//   Ports:
//     clk      clock
//     we_i     write enable
//     waddr_i  write address
//     wdata_i  write data
//     re_i     read enable; rdata_o only updates when set
//     raddr_i  read address
//     rdata_o  registered read data (read-during-write returns old data)
module trace_buffer_ram #(
  parameter int DW    = 48,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Both accesses are non-blocking in the same process, so a read of the
  // address being written sees the previous contents.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/trace_buffer.sv
// trace_buffer
//   On-chip pipeline trace recorder. Valid debug words are stored with a
//   free-running cycle stamp into a circular RAM while capturing. A masked
//   pattern trigger, a post-trigger depth and three capture modes (WRAP,
//   TRIG, FILL) decide when capture stops. The buffer is readable at any time.
//   Ports:
//     clk, rst         clock, asynchronous active-low reset
//     sample_i/valid_i debug word and its qualifier
//     arm_i            clear buffer, latch config, start capture
//     stop_i           force DONE while capturing
//     mode_i           0 WRAP, 1 TRIG, 2 FILL, 3 = TRIG
//     trig_mask_i/trig_val_i  trigger pattern
//     post_i           samples kept after the trigger sample
//     rd_addr_i/rd_en_i readout request
//     rd_data_o/rd_stamp_o/rd_valid_o  readout result, 1-cycle latency
//     state_o, triggered_o, trig_addr_o, wptr_o, count_o, oldest_o  status
module trace_buffer
  import trace_buffer_pkg::*;
#(
  parameter  int SW    = TB_DEFAULT_SW,
  parameter  int DEPTH = TB_DEFAULT_DEPTH,
  parameter  int CW    = TB_DEFAULT_CW,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [SW-1:0] sample_i,
  input  logic          valid_i,
  input  logic          arm_i,
  input  logic          stop_i,
  input  logic [1:0]    mode_i,
  input  logic [SW-1:0] trig_mask_i,
  input  logic [SW-1:0] trig_val_i,
  input  logic [AW-1:0] post_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic          rd_en_i,
  output logic [SW-1:0] rd_data_o,
  output logic [CW-1:0] rd_stamp_o,
  output logic          rd_valid_o,
  output logic [1:0]    state_o,
  output logic          triggered_o,
  output logic [AW-1:0] trig_addr_o,
  output logic [AW-1:0] wptr_o,
  output logic [AW:0]   count_o,
  output logic [AW-1:0] oldest_o
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  tb_state_e     state_q, state_d;
  tb_mode_e      mode_q, mode_d;
  logic [SW-1:0] mask_q, mask_d;
  logic [SW-1:0] val_q, val_d;
  logic [AW-1:0] post_q, post_d;
  logic [AW-1:0] remaining_q, remaining_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   count_q, count_d;
  logic          triggered_q, triggered_d;
  logic [AW-1:0] trig_addr_q, trig_addr_d;
  logic [CW-1:0] stamp_q;
  logic          rd_valid_q;
  logic          rd_seen_q;

  logic          capturing;
  logic          wr_en;
  logic          hit;
  logic [AW:0]   count_inc;
  logic [SW+CW-1:0] ram_rdata;

  assign capturing = (state_q == TB_ARMED) || (state_q == TB_POST);
  // arm and stop both suppress the write on their edge.
  assign wr_en     = capturing && valid_i && !arm_i && !stop_i;
  // Only the first hit after arming counts; triggered_q makes it sticky.
  assign hit       = (state_q == TB_ARMED) && valid_i && !triggered_q &&
                     (((sample_i ^ val_q) & mask_q) == '0);
  assign count_inc = (count_q == FULL) ? count_q : count_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= TB_IDLE;
      mode_q      <= TB_WRAP;
      mask_q      <= '0;
      val_q       <= '0;
      post_q      <= '0;
      remaining_q <= '0;
      wptr_q      <= '0;
      count_q     <= '0;
      triggered_q <= 1'b0;
      trig_addr_q <= '0;
      stamp_q     <= '0;
      rd_valid_q  <= 1'b0;
      rd_seen_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      mask_q      <= mask_d;
      val_q       <= val_d;
      post_q      <= post_d;
      remaining_q <= remaining_d;
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      triggered_q <= triggered_d;
      trig_addr_q <= trig_addr_d;
      stamp_q     <= stamp_q + 1'b1;
      rd_valid_q  <= rd_en_i;
      if (rd_en_i) begin
        rd_seen_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    mask_d      = mask_q;
    val_d       = val_q;
    post_d      = post_q;
    remaining_d = remaining_q;
    wptr_d      = wptr_q;
    count_d     = count_q;
    triggered_d = triggered_q;
    trig_addr_d = trig_addr_q;

    if (arm_i) begin
      // Restart from any state; arm outranks stop and trigger hits.
      state_d     = TB_ARMED;
      mode_d      = norm_mode(mode_i);
      mask_d      = trig_mask_i;
      val_d       = trig_val_i;
      post_d      = post_i;
      wptr_d      = '0;
      count_d     = '0;
      triggered_d = 1'b0;
      trig_addr_d = '0;
    end else if (capturing && stop_i) begin
      state_d = TB_DONE;
    end else if (wr_en) begin
      wptr_d  = wptr_q + 1'b1;
      count_d = count_inc;
      case (state_q)
        TB_ARMED: begin
          if (hit) begin
            triggered_d = 1'b1;
            trig_addr_d = wptr_q;
            if (mode_q == TB_TRIG) begin
              if (post_q == '0) begin
                state_d = TB_DONE;
              end else begin
                state_d     = TB_POST;
                remaining_d = post_q;
              end
            end
          end
          if ((mode_q == TB_FILL) && (count_inc == FULL)) begin
            state_d = TB_DONE;
          end
        end
        TB_POST: begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == 1'b1) begin
            state_d = TB_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  trace_buffer_ram #(
    .DW    (SW + CW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wptr_q),
    .wdata_i ({sample_i, stamp_q}),
    .re_i    (rd_en_i),
    .raddr_i (rd_addr_i),
    .rdata_o (ram_rdata)
  );

  // The RAM read register has no reset; keep the readout at zero until the
  // first read so the outputs are defined straight out of reset.
  assign rd_data_o   = rd_seen_q ? ram_rdata[SW+CW-1:CW] : '0;
  assign rd_stamp_o  = rd_seen_q ? ram_rdata[CW-1:0]     : '0;
  assign rd_valid_o  = rd_valid_q;
  assign state_o     = state_q;
  assign triggered_o = triggered_q;
  assign trig_addr_o = trig_addr_q;
  assign wptr_o      = wptr_q;
  assign count_o     = count_q;
  assign oldest_o    = (count_q == FULL) ? wptr_q : '0;

endmodule

// File: tb/tb_trace_buffer.sv
// tb_trace_buffer
//   Self-checking bench for trace_buffer. A shadow copy of the RAM is kept
//   from the driven stimulus; every read request pushes its expected word
//   onto a scoreboard queue that is popped when rd_valid_o comes back.
module tb_trace_buffer;

  localparam int SW    = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [SW-1:0] sample_i = '0;
  logic          valid_i = 1'b0;
  logic          arm_i = 1'b0;
  logic          stop_i = 1'b0;
  logic [1:0]    mode_i = '0;
  logic [SW-1:0] trig_mask_i = '0;
  logic [SW-1:0] trig_val_i = '0;
  logic [AW-1:0] post_i = '0;
  logic [AW-1:0] rd_addr_i = '0;
  logic          rd_en_i = 1'b0;
  logic [SW-1:0] rd_data_o;
  logic [CW-1:0] rd_stamp_o;
  logic          rd_valid_o;
  logic [1:0]    state_o;
  logic          triggered_o;
  logic [AW-1:0] trig_addr_o;
  logic [AW-1:0] wptr_o;
  logic [AW:0]   count_o;
  logic [AW-1:0] oldest_o;

  trace_buffer #(.SW(SW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .sample_i(sample_i), .valid_i(valid_i),
    .arm_i(arm_i), .stop_i(stop_i), .mode_i(mode_i),
    .trig_mask_i(trig_mask_i), .trig_val_i(trig_val_i), .post_i(post_i),
    .rd_addr_i(rd_addr_i), .rd_en_i(rd_en_i), .rd_data_o(rd_data_o),
    .rd_stamp_o(rd_stamp_o), .rd_valid_o(rd_valid_o), .state_o(state_o),
    .triggered_o(triggered_o), .trig_addr_o(trig_addr_o), .wptr_o(wptr_o),
    .count_o(count_o), .oldest_o(oldest_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            addr;
    logic [SW-1:0] data;
    logic [CW-1:0] stamp;
  } rd_exp_t;

  int            errors = 0;
  int            checks = 0;
  int unsigned   cyc = 0;
  logic [CW-1:0] edge_stamp;
  logic [SW-1:0] exp_data [DEPTH];
  logic [CW-1:0] exp_stamp [DEPTH];
  int            exp_wptr = 0;
  rd_exp_t       sb [$];

  // One clock edge; then pop the scoreboard if a read result is presented.
  task automatic tick();
    rd_exp_t e;
    @(posedge clk);
    edge_stamp = CW'(cyc);
    cyc++;
    #1;
    if (rd_valid_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_read: rd_valid_o=1 with empty scoreboard");
      end else begin
        e = sb.pop_front();
        $display("rd addr=%0d data=%h stamp=%0d exp_data=%h exp_stamp=%0d",
                 e.addr, rd_data_o, rd_stamp_o, e.data, e.stamp);
        if (rd_data_o !== e.data || rd_stamp_o !== e.stamp) begin
          errors++;
          $display("FAIL sb_read addr=%0d: got data=%h stamp=%0d, expected data=%h stamp=%0d",
                   e.addr, rd_data_o, rd_stamp_o, e.data, e.stamp);
        end
      end
    end
  endtask

  // Drive one cycle of sample input; record it in the shadow RAM when the
  // DUT is expected to write it.
  task automatic step(input logic v, input logic [SW-1:0] s, input logic wr);
    valid_i  = v;
    sample_i = s;
    tick();
    if (wr) begin
      exp_data[exp_wptr]  = s;
      exp_stamp[exp_wptr] = edge_stamp;
      exp_wptr = (exp_wptr + 1) % DEPTH;
    end
    valid_i = 1'b0;
  endtask

  task automatic rd_req(input int a);
    rd_exp_t e;
    rd_en_i   = 1'b1;
    rd_addr_i = AW'(a);
    e.addr  = a;
    e.data  = exp_data[a];
    e.stamp = exp_stamp[a];
    sb.push_back(e);
  endtask

  task automatic arm(input logic [1:0] m, input logic [SW-1:0] mask,
                     input logic [SW-1:0] val, input logic [AW-1:0] post);
    arm_i = 1'b1; mode_i = m; trig_mask_i = mask; trig_val_i = val; post_i = post;
    tick();
    arm_i = 1'b0;
    exp_wptr = 0;
    $display("arm mode=%0d mask=%h val=%h post=%0d", m, mask, val, post);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    if (state_o !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", state_o); end checks++;
    if (count_o !== '0) begin errors++; $display("FAIL rst_count: got %0d want 0", count_o); end checks++;
    if (triggered_o !== 1'b0 || trig_addr_o !== '0 || oldest_o !== '0) begin
      errors++; $display("FAIL rst_status: trig=%0d taddr=%0d oldest=%0d want 0", triggered_o, trig_addr_o, oldest_o);
    end checks++;
    if (rd_valid_o !== 1'b0 || rd_data_o !== '0 || rd_stamp_o !== '0) begin
      errors++; $display("FAIL rst_read: valid=%0d data=%h stamp=%0d want 0", rd_valid_o, rd_data_o, rd_stamp_o);
    end checks++;
    rst = 1'b1;
    cyc = 0;
    for (int i = 0; i < 10; i++) step(1'b1, SW'(i + 1), 1'b0);
    if (state_o !== 2'd0 || count_o !== '0 || wptr_o !== '0) begin
      errors++; $display("FAIL idle_no_capture: state=%0d count=%0d wptr=%0d want 0/0/0", state_o, count_o, wptr_o);
    end checks++;
  endtask

  task automatic test_trig();
    arm(2'd1, 32'hFFFF_FFFF, 32'h0000_00A5, AW'(3));
    if (state_o !== 2'd1 || count_o !== '0) begin
      errors++; $display("FAIL trig_armed: state=%0d count=%0d want 1/0", state_o, count_o);
    end checks++;
    for (int i = 1; i <= 13; i++) begin
      step(1'b1, (i == 10) ? 32'h0000_00A5 : SW'(i), 1'b1);
      if (i == 10) begin
        if (state_o !== 2'd2 || triggered_o !== 1'b1 || trig_addr_o !== AW'(9)) begin
          errors++; $display("FAIL trig_hit: state=%0d trig=%0d taddr=%0d want 2/1/9", state_o, triggered_o, trig_addr_o);
        end checks++;
      end
      if (i == 12) begin
        if (state_o !== 2'd2) begin errors++; $display("FAIL trig_post: state=%0d want 2", state_o); end checks++;
      end
    end
    if (state_o !== 2'd3 || count_o !== 7'd13 || wptr_o !== AW'(13)) begin
      errors++; $display("FAIL trig_done: state=%0d count=%0d wptr=%0d want 3/13/13", state_o, count_o, wptr_o);
    end checks++;
    step(1'b1, 32'd77, 1'b0);
    if (count_o !== 7'd13) begin errors++; $display("FAIL done_no_write: count=%0d want 13", count_o); end checks++;
  endtask

  task automatic test_readout();
    logic [CW-1:0] prev;
    prev = '0;
    for (int a = 0; a <= 12; a++) begin
      rd_req(a);
      step(1'b0, '0, 1'b0);
      if (a > 0) begin
        if (CW'(rd_stamp_o - prev) !== CW'(1)) begin
          errors++; $display("FAIL stamp_step addr=%0d: delta=%0d want 1", a, CW'(rd_stamp_o - prev));
        end checks++;
      end
      if (a == 9) begin
        if (rd_valid_o !== 1'b1 || rd_data_o !== 32'h0000_00A5) begin
          errors++; $display("FAIL read_trig_entry: valid=%0d data=%h want 1/000000a5", rd_valid_o, rd_data_o);
        end checks++;
      end
      prev = rd_stamp_o;
    end
    rd_en_i = 1'b0;
    step(1'b0, '0, 1'b0);
    if (rd_valid_o !== 1'b0 || rd_data_o !== 32'd13) begin
      errors++; $display("FAIL read_hold: valid=%0d data=%h want 0/0000000d", rd_valid_o, rd_data_o);
    end checks++;
  endtask

  task automatic test_wrap();
    arm(2'd0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, '0);
    for (int i = 0; i < 100; i++) step(1'b1, SW'(1000 + i), 1'b1);
    if (count_o !== 7'd64 || wptr_o !== AW'(36) || oldest_o !== AW'(36)) begin
      errors++; $display("FAIL wrap_ptrs: count=%0d wptr=%0d oldest=%0d want 64/36/36", count_o, wptr_o, oldest_o);
    end checks++;
    if (state_o !== 2'd1 || triggered_o !== 1'b0) begin
      errors++; $display("FAIL wrap_state: state=%0d trig=%0d want 1/0", state_o, triggered_o);
    end checks++;
    rd_req(36);
    step(1'b0, '0, 1'b0);
    rd_en_i = 1'b0;
    if (rd_data_o !== SW'(1036)) begin errors++; $display("FAIL wrap_oldest_data: got %0d want 1036", rd_data_o); end checks++;
  endtask

  task automatic test_fill();
    logic [CW-1:0] s1;
    arm(2'd2, '0, '0, '0);
    for (int i = 1; i <= 64; i++) begin
      step(1'b1, SW'(2000 + i), 1'b1);
      if (i == 1) begin
        if (triggered_o !== 1'b1 || trig_addr_o !== '0 || state_o !== 2'd1) begin
          errors++; $display("FAIL fill_trig: trig=%0d taddr=%0d state=%0d want 1/0/1", triggered_o, trig_addr_o, state_o);
        end checks++;
      end
      if (i < 64) step(1'b0, '0, 1'b0);
      if (i == 63) begin
        if (state_o !== 2'd1) begin errors++; $display("FAIL fill_63: state=%0d want 1", state_o); end checks++;
      end
    end
    if (state_o !== 2'd3 || count_o !== 7'd64 || oldest_o !== '0) begin
      errors++; $display("FAIL fill_done: state=%0d count=%0d oldest=%0d want 3/64/0", state_o, count_o, oldest_o);
    end checks++;
    rd_req(10);
    step(1'b0, '0, 1'b0);
    s1 = rd_stamp_o;
    rd_req(11);
    step(1'b0, '0, 1'b0);
    rd_en_i = 1'b0;
    if (CW'(rd_stamp_o - s1) !== CW'(2)) begin
      errors++; $display("FAIL fill_stamp_delta: got %0d want 2", CW'(rd_stamp_o - s1));
    end checks++;
  endtask

  task automatic test_priority();
    arm(2'd1, '0, '0, AW'(5));
    step(1'b1, 32'd3000, 1'b1);
    if (state_o !== 2'd2) begin errors++; $display("FAIL prio_post: state=%0d want 2", state_o); end checks++;
    arm_i = 1'b1; stop_i = 1'b1; trig_mask_i = 32'hFFFF_FFFF; trig_val_i = 32'h1234;
    step(1'b1, 32'h1234, 1'b0);
    arm_i = 1'b0; stop_i = 1'b0;
    exp_wptr = 0;
    if (state_o !== 2'd1 || count_o !== '0 || triggered_o !== 1'b0 || wptr_o !== '0) begin
      errors++; $display("FAIL prio_arm_stop: state=%0d count=%0d trig=%0d wptr=%0d want 1/0/0/0",
                         state_o, count_o, triggered_o, wptr_o);
    end checks++;
    stop_i = 1'b1;
    step(1'b1, 32'h1234, 1'b0);
    stop_i = 1'b0;
    if (state_o !== 2'd3 || count_o !== '0 || wptr_o !== '0) begin
      errors++; $display("FAIL prio_stop: state=%0d count=%0d wptr=%0d want 3/0/0", state_o, count_o, wptr_o);
    end checks++;
  endtask

  task automatic test_rdw();
    logic [SW-1:0] old_val;
    arm(2'd0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, '0);
    for (int i = 0; i < 3; i++) step(1'b1, SW'(4000 + i), 1'b1);
    old_val = exp_data[3];
    rd_req(3);
    step(1'b1, 32'd4003, 1'b1);
    if (rd_data_o !== old_val) begin
      errors++; $display("FAIL rdw_old: got %0d want %0d", rd_data_o, old_val);
    end checks++;
    rd_req(3);
    step(1'b0, '0, 1'b0);
    rd_en_i = 1'b0;
    if (rd_data_o !== 32'd4003) begin errors++; $display("FAIL rdw_new: got %0d want 4003", rd_data_o); end checks++;
  endtask

  task automatic test_async_reset();
    arm(2'd0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, '0);
    step(1'b1, 32'd5000, 1'b1);
    step(1'b1, 32'd5001, 1'b1);
    rst = 1'b0;
    #1;
    if (state_o !== 2'd0 || count_o !== '0 || wptr_o !== '0 || rd_data_o !== '0) begin
      errors++; $display("FAIL async_rst: state=%0d count=%0d wptr=%0d data=%h want 0",
                         state_o, count_o, wptr_o, rd_data_o);
    end checks++;
    tick();
    rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    test_reset();
    test_trig();
    test_readout();
    test_wrap();
    test_fill();
    test_priority();
    test_rdw();
    test_async_reset();
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain: %0d reads never returned", sb.size());
    end checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
